// File: rtl/idct_block_scheduler.sv
// Two-requester block scheduler in front of a row-based IDCT engine.
// Grants a full block of ROWS rows round-robin, then drains ROWS tagged result rows.
module idct_block_scheduler #(
    parameter int DIN_W  = 96,
    parameter int DOUT_W = 72,
    parameter int ROWS   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DIN_W-1:0]  s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DIN_W-1:0]  s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DIN_W-1:0]  eng_s_tdata,
    output logic              eng_s_tvalid,
    input  logic              eng_s_tready,
    input  logic [DOUT_W-1:0] eng_m_tdata,
    input  logic              eng_m_tvalid,
    output logic              eng_m_tready,
    output logic [DOUT_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tdest,
    input  logic              m_tready,
    output logic              err_tlast,
    output logic [15:0]       blk_count
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [2:0] LAST = 3'(ROWS - 1);

    state_t     state;
    state_t     state_nxt;
    logic       grant;
    logic [2:0] cnt;
    logic       any_req;
    logic       pick;
    logic       sel_valid;
    logic       sel_last;
    logic       last_row;
    logic       s_hs;
    logic       m_hs;

    assign any_req   = s0_tvalid | s1_tvalid;
    // On a tie the requester not served last wins; grant doubles as last-grant.
    assign pick      = (s0_tvalid & s1_tvalid) ? ~grant : s1_tvalid;
    assign sel_valid = grant ? s1_tvalid : s0_tvalid;
    assign sel_last  = grant ? s1_tlast : s0_tlast;
    assign last_row  = (cnt == LAST);
    assign s_hs      = (state == LOAD) & sel_valid & eng_s_tready;
    assign m_hs      = (state == DRAIN) & eng_m_tvalid & m_tready;

    assign eng_s_tdata = grant ? s1_tdata : s0_tdata;
    assign m_tdata     = eng_m_tdata;
    assign m_tdest     = grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    if (s_hs && last_row) state_nxt = DRAIN;
            DRAIN:   if (m_hs && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s0_tready    = 1'b0;
        s1_tready    = 1'b0;
        eng_s_tvalid = 1'b0;
        eng_m_tready = 1'b0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        unique case (state)
            LOAD: begin
                eng_s_tvalid = sel_valid;
                s0_tready    = ~grant & eng_s_tready;
                s1_tready    = grant & eng_s_tready;
            end
            DRAIN: begin
                m_tvalid     = eng_m_tvalid;
                eng_m_tready = m_tready;
                m_tlast      = last_row;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant     <= 1'b1;
            cnt       <= '0;
            blk_count <= '0;
            err_tlast <= 1'b0;
        end else begin
            if (state == IDLE && any_req) grant <= pick;
            if (s_hs || m_hs) cnt <= last_row ? 3'd0 : cnt + 3'd1;
            if (s_hs && (sel_last != last_row)) err_tlast <= 1'b1;
            if (m_hs && last_row) blk_count <= blk_count + 16'd1;
        end
    end

endmodule
